// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared defaults and vector computation for the nested interrupt controller
//   DEF_N_IRQ      default channel count
//   DEF_VEC_BASE   handler address of channel 0
//   DEF_VEC_STRIDE address distance between consecutive channel handlers
//   ID_NONE        channel id meaning "no channel" for the default channel count
//   vec_addr()     handler address for a channel id
package int_ctrl_pkg;
    localparam int          DEF_N_IRQ      = 3;
    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0009;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0033;
    localparam int          ID_NONE        = DEF_N_IRQ;

    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [31:0] stride,
                                             input logic [31:0] id);
        return base + id * stride;
    endfunction
endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-wins priority encoder with valid flag
//   i_req   request vector, bit 0 highest priority
//   o_id    index of the lowest set bit, N when none is set
//   o_valid any bit set
module int_prio_enc #(
    parameter int N    = 3,
    parameter int ID_W = $clog2(N + 1)
) (
    input  logic [N-1:0]    i_req,
    output logic [ID_W-1:0] o_id,
    output logic            o_valid
);
    always_comb begin
        o_id = ID_W'(N);
        for (int k = N - 1; k >= 0; k--)
            if (i_req[k]) o_id = ID_W'(k);
        o_valid = |i_req;
    end
endmodule

// File: rtl/int_ctrl_nested.sv
// int_ctrl_nested: N-channel vectored interrupt controller with nested in-service tracking
//   clk, CLR (async, active-high)  clock and reset
//   en          CP0 enable; freezes arbitration, eret and register writes when low
//   irq_in      raw asynchronous request lines, rising edge requests service
//   eret        return-from-interrupt, retires the highest-priority in-service level
//   ie_we/ie_wdata, mask_we/mask_wdata  register writes
//   int_req     one-cycle interrupt-taken pulse
//   int_addr    handler vector of cur_id (0 if none)
//   cur_id      highest-priority in-service channel (N_IRQ if none)
//   pending, in_service, ie  controller state
// Build option: define INT_CTRL_NEST_EN to allow preemption by higher-priority channels;
// without it only one handler level can be in service at a time.
module int_ctrl_nested
    import int_ctrl_pkg::*;
#(
    parameter int          N_IRQ      = DEF_N_IRQ,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
    parameter int          ID_W       = $clog2(N_IRQ + 1)
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             en,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             eret,
    input  logic             ie_we,
    input  logic             ie_wdata,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    output logic             int_req,
    output logic [31:0]      int_addr,
    output logic [ID_W-1:0]  cur_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service,
    output logic             ie
);
    logic [N_IRQ-1:0] r_s1, r_s2, r_s3, r_pending, r_in_service, r_mask;
    logic             r_ie, r_int_req;
    logic [N_IRQ-1:0] w_edge, w_acc_vec, w_ret_vec;
    logic [ID_W-1:0]  w_cand_id, w_cur_id;
    logic             w_cand_valid, w_cur_valid, w_prio_ok, w_accept, w_eret;

    int_prio_enc #(.N(N_IRQ), .ID_W(ID_W)) u_cand (
        .i_req(r_pending & r_mask), .o_id(w_cand_id), .o_valid(w_cand_valid)
    );
    int_prio_enc #(.N(N_IRQ), .ID_W(ID_W)) u_cur (
        .i_req(r_in_service), .o_id(w_cur_id), .o_valid(w_cur_valid)
    );

    always_comb begin
        w_edge = r_s2 & ~r_s3;
`ifdef INT_CTRL_NEST_EN
        w_prio_ok = !w_cur_valid || (w_cand_id < w_cur_id);
`else
        w_prio_ok = !w_cur_valid;
`endif
        w_eret    = en && eret;
        w_accept  = en && r_ie && !eret && w_cand_valid && w_prio_ok;
        w_acc_vec = w_accept ? (N_IRQ'(1) << w_cand_id) : '0;
        w_ret_vec = (w_eret && w_cur_valid) ? (N_IRQ'(1) << w_cur_id) : '0;
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            r_s1         <= '0;
            r_s2         <= '0;
            r_s3         <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_mask       <= '1;
            r_ie         <= 1'b1;
            r_int_req    <= 1'b0;
        end else begin
            r_s1         <= irq_in;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            // a fresh edge on the channel being accepted keeps its pending bit set
            r_pending    <= (r_pending & ~w_acc_vec) | w_edge;
            r_in_service <= (r_in_service | w_acc_vec) & ~w_ret_vec;
            r_int_req    <= w_accept;
            if (en && mask_we) r_mask <= mask_wdata;
            if (w_eret) r_ie <= 1'b1;
            else if (w_accept) r_ie <= 1'b0;
            else if (en && ie_we) r_ie <= ie_wdata;
        end
    end

    assign int_req    = r_int_req;
    assign cur_id     = w_cur_id;
    assign int_addr   = w_cur_valid ? vec_addr(VEC_BASE, VEC_STRIDE, 32'(w_cur_id)) : 32'h0;
    assign pending    = r_pending;
    assign in_service = r_in_service;
    assign ie         = r_ie;
endmodule

// File: tb/tb_int_ctrl_nested.sv
// tb_int_ctrl_nested: directed self-checking bench for int_ctrl_nested
module tb_int_ctrl_nested;
    logic        clk = 1'b0;
    logic        CLR = 1'b1;
    logic        en = 1'b1;
    logic [2:0]  irq_in = '0;
    logic        eret = 1'b0;
    logic        ie_we = 1'b0;
    logic        ie_wdata = 1'b0;
    logic        mask_we = 1'b0;
    logic [2:0]  mask_wdata = '0;
    logic        int_req;
    logic [31:0] int_addr;
    logic [1:0]  cur_id;
    logic [2:0]  pending;
    logic [2:0]  in_service;
    logic        ie;
    int          n_pass = 0;
    int          n_total = 0;

    int_ctrl_nested dut (
        .clk(clk), .CLR(CLR), .en(en), .irq_in(irq_in), .eret(eret),
        .ie_we(ie_we), .ie_wdata(ie_wdata), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .int_req(int_req), .int_addr(int_addr), .cur_id(cur_id), .pending(pending),
        .in_service(in_service), .ie(ie)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int max, output int lat);
        lat = 0;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (int_req === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic quiet();
        irq_in = '0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        repeat (2) tick();
        CLR = 1'b0;
        tick();
        n_total++; if (pending !== 3'b000) $display("FAIL reset_pending got %b exp 000", pending); else n_pass++;
        n_total++; if (in_service !== 3'b000) $display("FAIL reset_insvc got %b exp 000", in_service); else n_pass++;
        n_total++; if (ie !== 1'b1) $display("FAIL reset_ie got %b exp 1", ie); else n_pass++;
        n_total++; if (int_req !== 1'b0) $display("FAIL reset_int_req got %b exp 0", int_req); else n_pass++;
        n_total++; if (cur_id !== 2'd3) $display("FAIL reset_cur_id got %0d exp 3", cur_id); else n_pass++;
        n_total++; if (int_addr !== 32'h0) $display("FAIL reset_int_addr got %h exp 0", int_addr); else n_pass++;
    endtask

    task automatic test_single();
        int lat;
        irq_in = 3'b010;
        wait_req(6, lat);
        n_total++; if (lat < 1 || lat > 4) $display("FAIL single_latency got %0d exp 1..4", lat); else n_pass++;
        n_total++; if (int_addr !== 32'h3c) $display("FAIL single_addr got %h exp 3c", int_addr); else n_pass++;
        n_total++; if (cur_id !== 2'd1) $display("FAIL single_cur_id got %0d exp 1", cur_id); else n_pass++;
        n_total++; if (ie !== 1'b0) $display("FAIL single_ie got %b exp 0", ie); else n_pass++;
        tick();
        n_total++; if (int_req !== 1'b0) $display("FAIL single_pulse got %b exp 0", int_req); else n_pass++;
        do_eret();
        n_total++; if (in_service !== 3'b000) $display("FAIL single_eret_insvc got %b exp 000", in_service); else n_pass++;
        n_total++; if (ie !== 1'b1) $display("FAIL single_eret_ie got %b exp 1", ie); else n_pass++;
        n_total++; if (int_addr !== 32'h0) $display("FAIL single_eret_addr got %h exp 0", int_addr); else n_pass++;
        quiet();
    endtask

    task automatic test_priority();
        int lat;
        irq_in = 3'b101;
        wait_req(6, lat);
        n_total++; if (lat == 0) $display("FAIL prio_first_req got none exp pulse"); else n_pass++;
        n_total++; if (int_addr !== 32'h09) $display("FAIL prio_first_addr got %h exp 09", int_addr); else n_pass++;
        n_total++; if (pending !== 3'b100) $display("FAIL prio_pending got %b exp 100", pending); else n_pass++;
        do_eret();
        wait_req(6, lat);
        n_total++; if (lat == 0) $display("FAIL prio_second_req got none exp pulse"); else n_pass++;
        n_total++; if (int_addr !== 32'h6f) $display("FAIL prio_second_addr got %h exp 6f", int_addr); else n_pass++;
        do_eret();
        quiet();
    endtask

    task automatic test_nest();
        int lat;
        irq_in = 3'b100;
        wait_req(6, lat);
        n_total++; if (cur_id !== 2'd2) $display("FAIL nest_h2_cur_id got %0d exp 2", cur_id); else n_pass++;
        ie_we = 1'b1; ie_wdata = 1'b1;
        tick();
        ie_we = 1'b0; ie_wdata = 1'b0;
        n_total++; if (ie !== 1'b1) $display("FAIL nest_ie_write got %b exp 1", ie); else n_pass++;
        irq_in = 3'b101;
        wait_req(7, lat);
`ifdef INT_CTRL_NEST_EN
        n_total++; if (lat == 0) $display("FAIL nest_preempt_req got none exp pulse"); else n_pass++;
        n_total++; if (in_service !== 3'b101) $display("FAIL nest_insvc got %b exp 101", in_service); else n_pass++;
        n_total++; if (cur_id !== 2'd0) $display("FAIL nest_cur_id got %0d exp 0", cur_id); else n_pass++;
        do_eret();
        n_total++; if (cur_id !== 2'd2) $display("FAIL nest_ret_cur_id got %0d exp 2", cur_id); else n_pass++;
        n_total++; if (int_addr !== 32'h6f) $display("FAIL nest_ret_addr got %h exp 6f", int_addr); else n_pass++;
        do_eret();
`else
        n_total++; if (lat != 0) $display("FAIL flat_no_req got pulse at %0d exp none", lat); else n_pass++;
        n_total++; if (pending[0] !== 1'b1) $display("FAIL flat_pending0 got %b exp 1", pending[0]); else n_pass++;
        n_total++; if (in_service !== 3'b100) $display("FAIL flat_insvc got %b exp 100", in_service); else n_pass++;
        do_eret();
        wait_req(6, lat);
        n_total++; if (lat == 0) $display("FAIL flat_after_eret_req got none exp pulse"); else n_pass++;
        n_total++; if (cur_id !== 2'd0) $display("FAIL flat_cur_id got %0d exp 0", cur_id); else n_pass++;
        do_eret();
`endif
        n_total++; if (in_service !== 3'b000) $display("FAIL nest_final_insvc got %b exp 000", in_service); else n_pass++;
        quiet();
    endtask

    task automatic test_mask();
        int lat;
        mask_we = 1'b1; mask_wdata = 3'b110;
        tick();
        mask_we = 1'b0;
        irq_in = 3'b001;
        wait_req(7, lat);
        n_total++; if (lat != 0) $display("FAIL mask_no_req got pulse at %0d exp none", lat); else n_pass++;
        n_total++; if (pending !== 3'b001) $display("FAIL mask_pending got %b exp 001", pending); else n_pass++;
        mask_we = 1'b1; mask_wdata = 3'b111;
        tick();
        mask_we = 1'b0;
        wait_req(4, lat);
        n_total++; if (lat == 0) $display("FAIL unmask_req got none exp pulse"); else n_pass++;
        n_total++; if (int_addr !== 32'h09) $display("FAIL unmask_addr got %h exp 09", int_addr); else n_pass++;
        do_eret();
        quiet();
    endtask

    task automatic test_en_clr();
        int lat;
        en = 1'b0;
        irq_in = 3'b010;
        wait_req(7, lat);
        n_total++; if (lat != 0) $display("FAIL en0_no_req got pulse at %0d exp none", lat); else n_pass++;
        n_total++; if (pending !== 3'b010) $display("FAIL en0_pending got %b exp 010", pending); else n_pass++;
        en = 1'b1;
        tick();
        n_total++; if (int_req !== 1'b1) $display("FAIL en1_accept got %b exp 1", int_req); else n_pass++;
        n_total++; if (cur_id !== 2'd1) $display("FAIL en1_cur_id got %0d exp 1", cur_id); else n_pass++;
        en = 1'b0;
        tick();
        n_total++; if (int_req !== 1'b0) $display("FAIL en0_pulse_drop got %b exp 0", int_req); else n_pass++;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_total++; if (in_service !== 3'b010) $display("FAIL en0_eret_frozen got %b exp 010", in_service); else n_pass++;
        en = 1'b1;
        irq_in = 3'b011;
        repeat (3) tick();
        #2 CLR = 1'b1;
        #1;
        n_total++; if (in_service !== 3'b000) $display("FAIL clr_insvc got %b exp 000", in_service); else n_pass++;
        n_total++; if (pending !== 3'b000) $display("FAIL clr_pending got %b exp 000", pending); else n_pass++;
        n_total++; if (ie !== 1'b1) $display("FAIL clr_ie got %b exp 1", ie); else n_pass++;
        n_total++; if (cur_id !== 2'd3) $display("FAIL clr_cur_id got %0d exp 3", cur_id); else n_pass++;
        n_total++; if (int_addr !== 32'h0) $display("FAIL clr_addr got %h exp 0", int_addr); else n_pass++;
        irq_in = '0;
        tick();
        CLR = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_nest();
        test_mask();
        test_en_clr();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
